alu_cmd_seq: RTL



---
 rtl/alu_cmd_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command FIFO and serialising sequencer in front of a combinational ALU
// Optional response counters (stat_done, stat_divz) are built when ALU_SEQ_STATS_EN is defined.
module alu_cmd_seq #(
   parameter int FIFO_DEPTH = 4,
   parameter int OPW        = 4,
   parameter int DW         = 8,
   parameter int RW         = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [OPW-1:0] cmd_opcode,
   input  logic [DW-1:0]  cmd_a,
   input  logic [DW-1:0]  cmd_b,
   input  logic           cmd_use_acc,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_opcode,
   input  logic [RW-1:0]  alu_result,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [RW-1:0]  rsp_result,
   output logic           rsp_err
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0]    stat_done,
   output logic [15:0]    stat_divz
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [OPW-1:0] OP_NOP = OPW'(0);
   localparam logic [OPW-1:0] OP_DIV = OPW'(4);
   localparam logic [OPW-1:0] OP_CLR = OPW'(13);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t         state;
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [RW-1:0]  acc;

   logic [OPW-1:0] q_op  [FIFO_DEPTH];
   logic [DW-1:0]  q_a   [FIFO_DEPTH];
   logic [DW-1:0]  q_b   [FIFO_DEPTH];
   logic           q_acc [FIFO_DEPTH];

   logic          empty;
   logic          full;
   logic          push;
   logic [AW-1:0] rd_idx;
   logic          op_is_nop;

   // The extra MSB on each pointer separates full (MSBs differ) from empty (equal).
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign rd_idx    = rd_ptr[AW-1:0];
   assign op_is_nop = (alu_opcode == OP_NOP) || (alu_opcode > OP_CLR);

   always_ff @(posedge clk) begin
      if (push) begin
         q_op[wr_ptr[AW-1:0]]  <= cmd_opcode;
         q_a[wr_ptr[AW-1:0]]   <= cmd_a;
         q_b[wr_ptr[AW-1:0]]   <= cmd_b;
         q_acc[wr_ptr[AW-1:0]] <= cmd_use_acc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= OP_NOP;
         acc        <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
`ifdef ALU_SEQ_STATS_EN
         stat_done  <= '0;
         stat_divz  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  rd_ptr     <= rd_ptr + 1'b1;
                  alu_a      <= q_acc[rd_idx] ? acc[DW-1:0] : q_a[rd_idx];
                  alu_b      <= q_b[rd_idx];
                  alu_opcode <= q_op[rd_idx];
                  state      <= DRIVE;
               end
            end
            DRIVE: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               state     <= RESP;
               if (alu_opcode == OP_DIV && alu_b == '0) begin
                  rsp_result <= '1;
                  rsp_err    <= 1'b1;
               end else if (op_is_nop) begin
                  rsp_result <= acc;
               end else if (alu_opcode == OP_CLR) begin
                  rsp_result <= '0;
                  acc        <= '0;
               end else begin
                  rsp_result <= alu_result;
                  acc        <= alu_result;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
`ifdef ALU_SEQ_STATS_EN
                  stat_done <= stat_done + 16'd1;
                  if (rsp_err) stat_divz <= stat_divz + 16'd1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
